// File: rtl/guess_driver.sv
// Step-strobe generator and press delivery for the guessing-game FSM.
// Define GUESS_DRV_AUTO_EN to compile in the auto-player driven by `auto`/`target`/`y`.
module guess_driver #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic       auto,
    input  logic [1:0] target,
    input  logic [3:0] y,
    input  logic       win,
    input  logic       lose,
    output logic       en,
    output logic [3:0] b,
    output logic       done,
    output logic [7:0] press_cnt
);
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int DEB_W = $clog2(DEB_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [3:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]            level_q, level_d;
    logic [3:0]            press_q, press_d;
    logic [3:0]            pending_q, pending_d;
    logic [7:0]            press_cnt_q, press_cnt_d;
    logic [3:0]            new_press;

    always_comb begin
        en    = (div_q == DIV_W'(TICK_DIV - 1));
        div_d = en ? '0 : div_q + DIV_W'(1);
    end

    // Level flips only after DEB_CYCLES consecutive disagreeing samples; press_q marks the 0->1 flip.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_cnt_d = '0;
        level_d   = level_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
        press_d = level_d & ~level_q;
    end

`ifdef GUESS_DRV_AUTO_EN
    always_comb begin
        new_press = press_q;
        if (auto) begin
            new_press = 4'b0000;
            if ((state_q == IDLE) && (y == (4'b0001 << target))) begin
                new_press = y;
            end
        end
    end
`else
    logic unused_auto_inputs;
    assign unused_auto_inputs = ^{auto, target, y};
    assign new_press          = press_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Terminal flags win over consumption, which wins over a new press.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        press_cnt_d = press_cnt_q;
        if (win || lose) begin
            state_d   = DONE;
            pending_d = 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|new_press) begin
                        state_d   = PEND;
                        pending_d = new_press;
                    end
                end
                PEND: begin
                    if (en) begin
                        press_cnt_d = (press_cnt_q == 8'hFF) ? press_cnt_q : press_cnt_q + 8'd1;
                        if (|new_press) begin
                            pending_d = new_press;
                        end else begin
                            state_d   = IDLE;
                            pending_d = 4'b0000;
                        end
                    end else begin
                        pending_d = pending_q | new_press;
                    end
                end
                default: begin
                    state_d   = DONE;
                    pending_d = 4'b0000;
                end
            endcase
        end
    end

    always_comb begin
        b    = 4'b0000;
        done = 1'b0;
        case (state_q)
            PEND:    b    = pending_q;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign press_cnt = press_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_cnt_q   <= '0;
            level_q     <= '0;
            press_q     <= '0;
            pending_q   <= '0;
            press_cnt_q <= '0;
        end else begin
            div_q       <= div_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_cnt_q   <= deb_cnt_d;
            level_q     <= level_d;
            press_q     <= press_d;
            pending_q   <= pending_d;
            press_cnt_q <= press_cnt_d;
        end
    end

endmodule

// File: tb/tb_guess_driver.sv
// Scoreboard bench for guess_driver: each press pushes its expected guess, a monitor checks it at the consuming en.
// Auto-player scenario runs only when GUESS_DRV_AUTO_EN is defined.
module tb_guess_driver;
    localparam int TICK_DIV   = 8;
    localparam int DEB_CYCLES = 4;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic       auto;
    logic [1:0] target;
    logic [3:0] y;
    logic       win;
    logic       lose;
    logic       en;
    logic [3:0] b;
    logic       done;
    logic [7:0] press_cnt;

    typedef struct packed {
        logic [3:0] b;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_cnt;
    int         vec_cnt;
    int         err_cnt;

    guess_driver #(
        .TICK_DIV   (TICK_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .auto      (auto),
        .target    (target),
        .y         (y),
        .win       (win),
        .lose      (lose),
        .en        (en),
        .b         (b),
        .done      (done),
        .press_cnt (press_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] btn);
        btn_raw = btn;
    endtask

    // Press counter model saturates at 255, like the game-facing counter.
    task automatic expectDelivery(input logic [3:0] mask);
        exp_q.push_back({mask, exp_cnt});
        exp_cnt = (exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1;
    endtask

    task automatic waitEn(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 2 * TICK_DIV && !seen; c++) begin
            @(negedge clk);
            if (en) seen = 1'b1;
        end
        if (!seen) begin
            vec_cnt++;
            err_cnt++;
            $display("[TB] FAIL %s: got no en within %0d cycles, expected en", name, 2 * TICK_DIV);
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 8'd0;
    endtask

    // A delivery is any en cycle with a non-zero guess on b.
    task automatic monitorDeliveries();
        exp_t item;
        forever begin
            @(negedge clk);
            if (!rst && en && (b != 4'b0000)) begin
                if (exp_q.size() == 0) begin
                    vec_cnt++;
                    err_cnt++;
                    $display("[TB] FAIL unexpected_delivery: got b=%b press_cnt=%0d, expected none", b, press_cnt);
                end else begin
                    item = exp_q.pop_front();
                    checkOutput("delivery.b", 8'(b), 8'(item.b));
                    checkOutput("delivery.press_cnt", press_cnt, item.cnt);
                end
            end
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        exp_cnt = 8'd0;
        rst     = 1'b1;
        btn_raw = 4'b0000;
        auto    = 1'b0;
        target  = 2'd0;
        y       = 4'b0000;
        win     = 1'b0;
        lose    = 1'b0;
        fork
            monitorDeliveries();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.en", 8'(en), 8'd0);
        checkOutput("reset.b", 8'(b), 8'd0);
        checkOutput("reset.done", 8'(done), 8'd0);
        checkOutput("reset.press_cnt", press_cnt, 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            checkOutput("strobe.en", 8'(en), 8'(n % TICK_DIV == 0));
        end

        for (int t = 0; t < 20; t++) begin
            applyStimulus({1'b0, ((t / 2) % 2 == 0), 2'b00});
            @(negedge clk);
            checkOutput("bounce.quiet_b", 8'(b), 8'd0);
        end
        applyStimulus(4'b0100);
        expectDelivery(4'b0100);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("bounce.b_timing", 8'(b), (k == 7) ? 8'h04 : 8'h00);
        end
        waitEn("bounce.wait_en");
        @(negedge clk);
        checkOutput("bounce.b_cleared", 8'(b), 8'd0);
        checkOutput("bounce.press_cnt", press_cnt, 8'd1);
        applyStimulus(4'b0000);

        // Rise two cycles after an en so the press lands exactly on the next en.
        waitEn("coincide.align");
        repeat (2) @(negedge clk);
        applyStimulus(4'b0001);
        expectDelivery(4'b0001);
        repeat (6) @(negedge clk);
        checkOutput("coincide.en_at_press", 8'(en), 8'd1);
        checkOutput("coincide.b_missed", 8'(b), 8'd0);
        @(negedge clk);
        checkOutput("coincide.b_loaded", 8'(b), 8'h01);
        waitEn("coincide.wait_en");
        @(negedge clk);
        checkOutput("coincide.b_cleared", 8'(b), 8'd0);
        checkOutput("coincide.press_cnt", press_cnt, 8'd2);
        applyStimulus(4'b0000);

        waitEn("pend_en.align");
        @(negedge clk);
        applyStimulus(4'b1000);
        expectDelivery(4'b1000);
        @(negedge clk);
        applyStimulus(4'b1010);
        expectDelivery(4'b0010);
        repeat (6) @(negedge clk);
        checkOutput("pend_en.en", 8'(en), 8'd1);
        @(negedge clk);
        checkOutput("pend_en.b_replaced", 8'(b), 8'h02);
        checkOutput("pend_en.press_cnt", press_cnt, 8'd3);
        applyStimulus(4'b0000);

        waitEn("or.align");
        repeat (2) @(negedge clk);
        applyStimulus(4'b1000);
        expectDelivery(4'b1010);
        @(negedge clk);
        applyStimulus(4'b1010);
        repeat (6) @(negedge clk);
        checkOutput("or.b_first", 8'(b), 8'h08);
        @(negedge clk);
        checkOutput("or.b_merged", 8'(b), 8'h0A);
        waitEn("or.wait_en");
        @(negedge clk);
        checkOutput("or.b_cleared", 8'(b), 8'd0);
        checkOutput("or.press_cnt", press_cnt, 8'd5);
        applyStimulus(4'b0000);

        waitEn("term.align");
        repeat (2) @(negedge clk);
        applyStimulus(4'b0010);
        repeat (7) @(negedge clk);
        checkOutput("term.pend_b", 8'(b), 8'h02);
        checkOutput("term.pend_en", 8'(en), 8'd0);
        lose = 1'b1;
        @(negedge clk);
        checkOutput("term.b", 8'(b), 8'd0);
        checkOutput("term.done", 8'(done), 8'd1);
        checkOutput("term.press_cnt", press_cnt, 8'd5);
        lose = 1'b0;
        applyStimulus(4'b0000);
        repeat (8) @(negedge clk);
        applyStimulus(4'b0001);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("term.ignored_b", 8'(b), 8'd0);
        end
        checkOutput("term.done_held", 8'(done), 8'd1);
        checkOutput("term.press_cnt_held", press_cnt, 8'd5);
        applyStimulus(4'b0000);
        checkOutput("sb.drained_before_reset", 8'(exp_q.size()), 8'd0);

        pulseReset();
        @(negedge clk);
        checkOutput("rerst.done", 8'(done), 8'd0);
        checkOutput("rerst.b", 8'(b), 8'd0);
        checkOutput("rerst.press_cnt", press_cnt, 8'd0);

        for (int k = 0; k < 260; k++) begin
            applyStimulus(4'((k % 15) + 1));
            expectDelivery(4'((k % 15) + 1));
            repeat (16) @(negedge clk);
            applyStimulus(4'b0000);
            repeat (16) @(negedge clk);
        end
        checkOutput("sat.press_cnt", press_cnt, 8'd255);

`ifdef GUESS_DRV_AUTO_EN
        begin : auto_test
            logic [3:0] b_seen;
            bit         auto_checked;
            auto_checked = 1'b0;
            auto   = 1'b1;
            target = 2'd2;
            y      = 4'b0001;
            pulseReset();
            expectDelivery(4'b0100);
            // Game model: on each en edge judge a non-zero guess against y, otherwise rotate y.
            for (int c = 0; c < 6 * TICK_DIV && !win && !lose; c++) begin
                @(negedge clk);
                if (en) begin
                    b_seen = b;
                    @(posedge clk);
                    #1;
                    if (b_seen != 4'b0000) begin
                        if (b_seen == y) win = 1'b1;
                        else lose = 1'b1;
                    end else begin
                        y = {y[2:0], y[3]};
                    end
                    if ((y == 4'b0100) && !win && !lose && !auto_checked) begin
                        auto_checked = 1'b1;
                        @(negedge clk);
                        checkOutput("auto.match_cycle_b", 8'(b), 8'd0);
                        @(negedge clk);
                        checkOutput("auto.b_load", 8'(b), 8'h04);
                    end
                end
            end
            checkOutput("auto.win", 8'(win), 8'd1);
            checkOutput("auto.lose", 8'(lose), 8'd0);
            repeat (2) @(negedge clk);
            checkOutput("auto.done", 8'(done), 8'd1);
            checkOutput("auto.press_cnt", press_cnt, 8'd1);
            win  = 1'b0;
            lose = 1'b0;
            auto = 1'b0;
        end
`endif

        repeat (2) @(negedge clk);
        checkOutput("sb.drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
